dp_run_ctrl: RTL and testbench
==============================

// Module: dp_run_ctrl
// PURPOSE
//  Host-side sequencer for the 4-thread RISC-V datapath. Executes one host command at a time:
//  - load i_mem
//  - load d_mem
//  - run the core for a cycle budget, then drain
//  - read back d_mem
//  Drives the datapath's i_mem/d_mem load ports, pc_en and datapath reset; sits between the host bus and the datapath.
// PARAMETERS
//  D_WIDTH    64  data word width (d_mem, host streams)
//  I_WIDTH    32  instruction width
//  PC_WIDTH   32  width of i_mem_addra
//  IADDR_W    9   i_mem word-index width (512 words)
//  DADDR_W    8   d_mem word-index width (256 words)
//  CYC_W      16  run-cycle budget width
//  RST_CYC    2   cycles dp_reset_n held low before RUN (>=1)
//  DRAIN_CYC  3   pc_en-low cycles after RUN so the EX/MEM and MEM/WB stages retire (>=2)
//  READ_LAT   1   d_mem port-B read latency in cycles (>=1)
// PORTS
//  clk          in   1        clock
//  reset_n      in   1        synchronous, active-low reset
//  cmd_valid    in   1        command request
//  cmd_ready    out  1        high only in IDLE
//  cmd_op       in   2        00 LOAD_I, 01 LOAD_D, 10 RUN, 11 READ_D
//  cmd_addr     in   IADDR_W  start word index (LOAD/READ); d_mem uses [DADDR_W-1:0]
//  cmd_len      in   IADDR_W  word count minus 1 (LOAD/READ)
//  cmd_cycles   in   CYC_W    pc_en-high cycles (RUN)
//  wr_valid     in   1        host write-data beat valid
//  wr_ready     out  1        high in LOAD_I/LOAD_D
//  wr_data      in   D_WIDTH  write data; LOAD_I uses [I_WIDTH-1:0]
//  rd_valid     out  1        readback beat valid
//  rd_ready     in   1        host accepts readback beat
//  rd_data      out  D_WIDTH  readback data
//  i_mem_addra  out  PC_WIDTH i_mem write word index, zero-extended
//  i_mem_din    out  I_WIDTH  i_mem write data
//  i_mem_we     out  1        i_mem write enable
//  d_mem_addra  out  DADDR_W  d_mem port-B address
//  d_mem_din    out  D_WIDTH  d_mem port-B write data
//  d_mem_we     out  1        d_mem port-B write enable
//  d_mem_out    in   D_WIDTH  d_mem port-B read data
//  pc_en        out  1        datapath fetch/ID/EX enable
//  dp_reset_n   out  1        datapath sync reset, active low
//  busy         out  1        state != IDLE
//  done         out  1        one-cycle pulse when a command completes
// BEHAVIOUR
//  Reset values:
//  - state=IDLE
//  - cmd_ready=1, busy=0
//  - all *_we, wr_ready, rd_valid, pc_en, done = 0
//  - addresses and data = 0
//  - dp_reset_n=0
//  Reset mid-command drops the command immediately; no partial writes issue after reset.
//  States: IDLE, LOAD_I, LOAD_D, DP_RST, RUN, DRAIN, RD_ADDR, RD_WAIT, RD_OUT.
//  IDLE: on cmd_valid, latch the command and go to LOAD_I/LOAD_D/DP_RST/RD_ADDR according to cmd_op.
//  LOAD_x:
//  - Each wr_valid&wr_ready beat registers addr=base+n, data and we=1, so the write appears on the ports 1 cycle after the beat.
//  - After beat cmd_len+1, go to IDLE; done pulses in the same cycle as the last we.
//  DP_RST: dp_reset_n=0 for RST_CYC cycles, then RUN.
//  RUN:
//  - dp_reset_n=1, pc_en=1 for exactly cmd_cycles cycles.
//  - cmd_cycles=0 skips RUN straight to DRAIN.
//  DRAIN: pc_en=0, dp_reset_n=1 for DRAIN_CYC cycles, then IDLE with a done pulse.
//  dp_reset_n is 0 in every state except RUN and DRAIN (core held in reset while idle or loading).
//  Readback:
//  - RD_ADDR drives the address.
//  - RD_WAIT waits READ_LAT cycles, then captures d_mem_out into rd_data.
//  - RD_OUT holds rd_valid until rd_ready. rd_data and rd_valid are stable while stalled.
//  - After the handshake: next word, or IDLE with done after word cmd_len+1.
//  Addresses wrap modulo 2^IADDR_W (i_mem) and 2^DADDR_W (d_mem); cmd_len above the d_mem depth wraps.
//  The word counter is IADDR_W+1 bits wide, so cmd_len=all-ones yields 2^IADDR_W beats.
//  cmd_valid outside IDLE is ignored (cmd_ready=0).
// CONFIGURATION
//  DP_RUN_CTRL_ABORT_EN defined:
//  - Adds input abort (1 bit).
//  - abort in RUN or DP_RST goes to DRAIN, so the drain always completes.
//  - abort in LOAD/READ states goes to IDLE after the current beat; no done pulse.
//  - abort in IDLE has no effect.
//  DP_RUN_CTRL_ABORT_EN undefined: no abort port; commands always run to completion.
// STRUCTURE
//  Package dp_ctrl_pkg holds:
//  - op encodings OP_LOAD_I/OP_LOAD_D/OP_RUN/OP_READ_D
//  - the state enum
//  One sub-module dp_beat_counter (loadable down-counter, zero flag), instanced for:
//  - word count
//  - cycle budget
//  - RST/DRAIN/READ_LAT waits
// TESTING
//  1 LOAD_I addr=0 len=3, data 0x13,0x93,0x113,0x193 -> i_mem_we on 4 cycles, addra 0..3, done with the last we.
//  2 RUN cycles=8 -> dp_reset_n low 2 cycles, pc_en high exactly 8 cycles, 3 drain cycles, done, cmd_ready=1.
//  3 READ_D addr=0xFE len=3, rd_ready low 5 cycles on beat 1 -> addrs FE,FF,00,01 and rd_data stable while stalled.
//  4 LOAD_D with wr_valid gaps, then RUN cycles=0 -> no pc_en, DRAIN only, done; writes land at correct addrs.
//  5 reset_n low mid-RUN and mid-LOAD_D -> next cycle pc_en=0, we=0, dp_reset_n=0, state IDLE, no done.
//  6 (ABORT_EN) abort at RUN cycle 3 of 100 -> pc_en drops, 3 drain cycles, done pulse.

Source files
------------

// File: rtl/dp_run_ctrl_pkg.sv
// Shared encodings for the datapath run controller: host command opcodes,
// sequencer states and the width of the short wait counter.
package dp_ctrl_pkg;

  localparam logic [1:0] OP_LOAD_I = 2'b00;
  localparam logic [1:0] OP_LOAD_D = 2'b01;
  localparam logic [1:0] OP_RUN    = 2'b10;
  localparam logic [1:0] OP_READ_D = 2'b11;

  localparam int WAIT_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_I,
    ST_LOAD_D,
    ST_DP_RST,
    ST_RUN,
    ST_DRAIN,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_RD_OUT
  } state_t;

endpackage

// File: rtl/dp_run_ctrl_if.sv
// Host-side command, write-stream and readback-stream bundle of the run controller.
// master = host side, slave = controller side.
interface dp_run_ctrl_if #(
  parameter int D_WIDTH = 64,
  parameter int IADDR_W = 9,
  parameter int CYC_W   = 16
) ();

  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [IADDR_W-1:0] cmd_addr;
  logic [IADDR_W-1:0] cmd_len;
  logic [CYC_W-1:0]   cmd_cycles;
  logic               wr_valid;
  logic               wr_ready;
  logic [D_WIDTH-1:0] wr_data;
  logic               rd_valid;
  logic               rd_ready;
  logic [D_WIDTH-1:0] rd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_cycles, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_cycles, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data
  );

endinterface

// File: rtl/dp_beat_counter.sv
// Loadable down-counter with a zero flag; saturates at zero so a stray
// decrement can never wrap into a huge count.
module dp_beat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && !zero) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/dp_run_ctrl.sv
// Host-side sequencer for the 4-thread datapath: loads i_mem/d_mem, runs the core
// for a cycle budget then drains, and reads d_mem back. Optional abort input: DP_RUN_CTRL_ABORT_EN.
module dp_run_ctrl
  import dp_ctrl_pkg::*;
#(
  parameter int D_WIDTH   = 64,
  parameter int I_WIDTH   = 32,
  parameter int PC_WIDTH  = 32,
  parameter int IADDR_W   = 9,
  parameter int DADDR_W   = 8,
  parameter int CYC_W     = 16,
  parameter int RST_CYC   = 2,
  parameter int DRAIN_CYC = 3,
  parameter int READ_LAT  = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  dp_run_ctrl_if.slave        host,
`ifdef DP_RUN_CTRL_ABORT_EN
  input  logic                abort,
`endif
  output logic [PC_WIDTH-1:0] i_mem_addra,
  output logic [I_WIDTH-1:0]  i_mem_din,
  output logic                i_mem_we,
  output logic [DADDR_W-1:0]  d_mem_addra,
  output logic [D_WIDTH-1:0]  d_mem_din,
  output logic                d_mem_we,
  input  logic [D_WIDTH-1:0]  d_mem_out,
  output logic                pc_en,
  output logic                dp_reset_n,
  output logic                busy,
  output logic                done
);

  localparam logic [WAIT_W-1:0] RST_LOAD   = WAIT_W'(RST_CYC - 1);
  localparam logic [WAIT_W-1:0] DRAIN_LOAD = WAIT_W'(DRAIN_CYC - 1);
  localparam logic [WAIT_W-1:0] READ_LOAD  = WAIT_W'(READ_LAT - 1);

  state_t              state_reg, state_next;
  logic [IADDR_W-1:0]  addr_reg;
  logic [IADDR_W-1:0]  addr_next;
  logic                beat;
  logic                wcnt_load, wcnt_dec, wcnt_zero;
  logic                ccnt_load, ccnt_dec, ccnt_zero;
  logic                wait_load, wait_dec, wait_zero;
  logic [WAIT_W-1:0]   wait_val;
  logic                addr_load, addr_inc;
  logic                rd_addr_set;
  logic [DADDR_W-1:0]  rd_addr_val;
  logic                capture;
  logic                done_next;
  logic                abort_req, abort_rd;

`ifdef DP_RUN_CTRL_ABORT_EN
  // A read abort is remembered until the word in flight has been handed over.
  logic abort_pend_reg;

  always_ff @(posedge clk) begin
    if (!reset_n || state_reg == ST_IDLE) begin
      abort_pend_reg <= 1'b0;
    end else if (abort) begin
      abort_pend_reg <= 1'b1;
    end
  end

  assign abort_req = abort;
  assign abort_rd  = abort | abort_pend_reg;
`else
  assign abort_req = 1'b0;
  assign abort_rd  = 1'b0;
`endif

  assign host.cmd_ready = (state_reg == ST_IDLE);
  assign host.wr_ready  = (state_reg == ST_LOAD_I) || (state_reg == ST_LOAD_D);
  assign host.rd_valid  = (state_reg == ST_RD_OUT);
  assign busy           = (state_reg != ST_IDLE);
  assign pc_en          = (state_reg == ST_RUN);
  assign dp_reset_n     = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);

  assign beat      = host.wr_valid & host.wr_ready;
  assign addr_next = addr_reg + 1'b1;

  dp_beat_counter #(.WIDTH(IADDR_W + 1)) u_word_cnt (
    .clk(clk), .reset_n(reset_n), .load(wcnt_load), .dec(wcnt_dec),
    .load_val({1'b0, host.cmd_len}), .zero(wcnt_zero)
  );

  dp_beat_counter #(.WIDTH(CYC_W)) u_cycle_cnt (
    .clk(clk), .reset_n(reset_n), .load(ccnt_load), .dec(ccnt_dec),
    .load_val(host.cmd_cycles), .zero(ccnt_zero)
  );

  dp_beat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk(clk), .reset_n(reset_n), .load(wait_load), .dec(wait_dec),
    .load_val(wait_val), .zero(wait_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    wcnt_load   = 1'b0;
    wcnt_dec    = 1'b0;
    ccnt_load   = 1'b0;
    ccnt_dec    = 1'b0;
    wait_load   = 1'b0;
    wait_dec    = 1'b0;
    wait_val    = '0;
    addr_load   = 1'b0;
    addr_inc    = 1'b0;
    rd_addr_set = 1'b0;
    rd_addr_val = addr_next[DADDR_W-1:0];
    capture     = 1'b0;
    done_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (host.cmd_valid) begin
          wcnt_load = 1'b1;
          ccnt_load = 1'b1;
          addr_load = 1'b1;
          case (host.cmd_op)
            OP_LOAD_I: state_next = ST_LOAD_I;
            OP_LOAD_D: state_next = ST_LOAD_D;
            OP_RUN: begin
              state_next = ST_DP_RST;
              wait_load  = 1'b1;
              wait_val   = RST_LOAD;
            end
            default: begin
              state_next  = ST_RD_ADDR;
              rd_addr_set = 1'b1;
              rd_addr_val = host.cmd_addr[DADDR_W-1:0];
            end
          endcase
        end
      end
      ST_LOAD_I, ST_LOAD_D: begin
        if (beat) begin
          addr_inc = 1'b1;
          wcnt_dec = 1'b1;
          if (wcnt_zero) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
        if (abort_req) begin
          state_next = ST_IDLE;
          done_next  = 1'b0;
        end
      end
      ST_DP_RST: begin
        if (abort_req || (wait_zero && ccnt_zero)) begin
          state_next = ST_DRAIN;
          wait_load  = 1'b1;
          wait_val   = DRAIN_LOAD;
        end else if (wait_zero) begin
          // First RUN cycle is consumed here so RUN exits when the budget hits zero.
          state_next = ST_RUN;
          ccnt_dec   = 1'b1;
        end else begin
          wait_dec = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort_req || ccnt_zero) begin
          state_next = ST_DRAIN;
          wait_load  = 1'b1;
          wait_val   = DRAIN_LOAD;
        end else begin
          ccnt_dec = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (wait_zero) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else begin
          wait_dec = 1'b1;
        end
      end
      ST_RD_ADDR: begin
        state_next = ST_RD_WAIT;
        wait_load  = 1'b1;
        wait_val   = READ_LOAD;
      end
      ST_RD_WAIT: begin
        if (wait_zero) begin
          capture    = 1'b1;
          state_next = ST_RD_OUT;
        end else begin
          wait_dec = 1'b1;
        end
      end
      ST_RD_OUT: begin
        if (host.rd_ready) begin
          if (wcnt_zero || abort_rd) begin
            state_next = ST_IDLE;
            done_next  = !abort_rd;
          end else begin
            wcnt_dec    = 1'b1;
            addr_inc    = 1'b1;
            rd_addr_set = 1'b1;
            state_next  = ST_RD_ADDR;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_reg     <= '0;
      i_mem_addra  <= '0;
      i_mem_din    <= '0;
      i_mem_we     <= 1'b0;
      d_mem_addra  <= '0;
      d_mem_din    <= '0;
      d_mem_we     <= 1'b0;
      host.rd_data <= '0;
      done         <= 1'b0;
    end else begin
      done     <= done_next;
      i_mem_we <= beat && (state_reg == ST_LOAD_I);
      d_mem_we <= beat && (state_reg == ST_LOAD_D);
      if (beat && state_reg == ST_LOAD_I) begin
        i_mem_addra <= PC_WIDTH'(addr_reg);
        i_mem_din   <= host.wr_data[I_WIDTH-1:0];
      end
      if (beat && state_reg == ST_LOAD_D) begin
        d_mem_addra <= addr_reg[DADDR_W-1:0];
        d_mem_din   <= host.wr_data;
      end else if (rd_addr_set) begin
        d_mem_addra <= rd_addr_val;
      end
      if (addr_load) begin
        addr_reg <= host.cmd_addr;
      end else if (addr_inc) begin
        addr_reg <= addr_next;
      end
      if (capture) begin
        host.rd_data <= d_mem_out;
      end
    end
  end

endmodule

// File: tb/tb_dp_run_ctrl.sv
// Directed bench for dp_run_ctrl: a per-cycle timeline model built from the command
// rules, compared against the DUT every cycle. Abort test needs DP_RUN_CTRL_ABORT_EN.
module tb_dp_run_ctrl;
  import dp_ctrl_pkg::*;

  localparam int RST_CYC   = 2;
  localparam int DRAIN_CYC = 3;
  localparam int READ_LAT  = 1;

  typedef struct {
    logic        cmd_ready, busy, wr_ready, rd_valid, pc_en, rst_n;
    logic        i_we, d_we, done, chk_daddr, chk_zero;
    logic [31:0] i_addr, i_din;
    logic [7:0]  d_addr;
    logic [63:0] d_din, rd_data;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dp_run_ctrl_if #(.D_WIDTH(64), .IADDR_W(9), .CYC_W(16)) host ();

  logic [31:0] i_mem_addra;
  logic [31:0] i_mem_din;
  logic        i_mem_we;
  logic [7:0]  d_mem_addra;
  logic [63:0] d_mem_din;
  logic        d_mem_we;
  logic [63:0] d_mem_out;
  logic        pc_en, dp_reset_n, busy, done;
`ifdef DP_RUN_CTRL_ABORT_EN
  logic        abort;
`endif

  dp_run_ctrl dut (
    .clk(clk), .reset_n(reset_n), .host(host.slave),
`ifdef DP_RUN_CTRL_ABORT_EN
    .abort(abort),
`endif
    .i_mem_addra(i_mem_addra), .i_mem_din(i_mem_din), .i_mem_we(i_mem_we),
    .d_mem_addra(d_mem_addra), .d_mem_din(d_mem_din), .d_mem_we(d_mem_we),
    .d_mem_out(d_mem_out), .pc_en(pc_en), .dp_reset_n(dp_reset_n),
    .busy(busy), .done(done)
  );

  // d_mem port B: one-cycle registered read
  logic [63:0] dmem [256];
  always @(posedge clk) begin
    if (d_mem_we) dmem[d_mem_addra] <= d_mem_din;
    d_mem_out <= dmem[d_mem_addra];
  end

  logic [63:0] ref_mem [256];
  exp_t exp_cur;
  int checks = 0;
  int errors = 0;
  int pc_cnt = 0;
  int iwe_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic compare_outputs();
    chk("cmd_ready", 64'(host.cmd_ready), 64'(exp_cur.cmd_ready));
    chk("busy", 64'(busy), 64'(exp_cur.busy));
    chk("wr_ready", 64'(host.wr_ready), 64'(exp_cur.wr_ready));
    chk("rd_valid", 64'(host.rd_valid), 64'(exp_cur.rd_valid));
    chk("pc_en", 64'(pc_en), 64'(exp_cur.pc_en));
    chk("dp_reset_n", 64'(dp_reset_n), 64'(exp_cur.rst_n));
    chk("i_mem_we", 64'(i_mem_we), 64'(exp_cur.i_we));
    chk("d_mem_we", 64'(d_mem_we), 64'(exp_cur.d_we));
    chk("done", 64'(done), 64'(exp_cur.done));
    if (exp_cur.i_we) begin
      chk("i_mem_addra", 64'(i_mem_addra), 64'(exp_cur.i_addr));
      chk("i_mem_din", 64'(i_mem_din), 64'(exp_cur.i_din));
    end
    if (exp_cur.d_we) begin
      chk("d_mem_addra_wr", 64'(d_mem_addra), 64'(exp_cur.d_addr));
      chk("d_mem_din", d_mem_din, exp_cur.d_din);
    end
    if (exp_cur.chk_daddr) chk("d_mem_addra_rd", 64'(d_mem_addra), 64'(exp_cur.d_addr));
    if (exp_cur.rd_valid) chk("rd_data", host.rd_data, exp_cur.rd_data);
    if (exp_cur.chk_zero) begin
      chk("rst_i_addra", 64'(i_mem_addra), 64'h0);
      chk("rst_i_din", 64'(i_mem_din), 64'h0);
      chk("rst_d_addra", 64'(d_mem_addra), 64'h0);
      chk("rst_d_din", d_mem_din, 64'h0);
      chk("rst_rd_data", host.rd_data, 64'h0);
    end
    pc_cnt   += int'(pc_en);
    iwe_cnt  += int'(i_mem_we);
    done_cnt += int'(done);
  endtask

  // Compare this cycle's outputs at the falling edge, then move to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t e_idle();
    exp_t e;
    e = '{default: '0};
    e.cmd_ready = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_busy(input logic rn, input logic pc);
    exp_t e;
    e = '{default: '0};
    e.busy  = 1'b1;
    e.rst_n = rn;
    e.pc_en = pc;
    return e;
  endfunction

  function automatic exp_t e_load();
    exp_t e;
    e = e_busy(1'b0, 1'b0);
    e.wr_ready = 1'b1;
    return e;
  endfunction

  function automatic exp_t with_we(input exp_t e, input logic [1:0] op, input logic [8:0] pa, input logic [63:0] pd);
    exp_t r;
    r = e;
    if (op == OP_LOAD_I) begin
      r.i_we = 1'b1; r.i_addr = {23'h0, pa}; r.i_din = pd[31:0];
    end else begin
      r.d_we = 1'b1; r.d_addr = pa[7:0]; r.d_din = pd;
    end
    return r;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [8:0] addr, input logic [8:0] len, input logic [15:0] cyc);
    exp_cur = e_idle();
    host.cmd_valid = 1'b1; host.cmd_op = op; host.cmd_addr = addr;
    host.cmd_len = len; host.cmd_cycles = cyc;
    step();
    host.cmd_valid = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] op, input logic [8:0] addr, input logic [8:0] len, input bit gaps);
    int n = 0;
    int k = 0;
    bit have_prev = 0;
    logic [8:0] pa = '0;
    logic [63:0] pd = '0;
    issue(op, addr, len, 16'd0);
    while (n <= int'(len)) begin
      exp_cur = e_load();
      if (have_prev) exp_cur = with_we(exp_cur, op, pa, pd);
      host.wr_valid = !gaps || (k % 3 != 1);
      if (host.wr_valid) begin
        pa = addr + 9'(n);
        pd = (op == OP_LOAD_I) ? 64'h13 + 64'h80 * 64'(n)
                               : 64'hDA7A_0000_0000_0000 | (64'(pa) << 16) | 64'(n);
        host.wr_data = pd;
        if (op == OP_LOAD_D) ref_mem[pa[7:0]] = pd;
        have_prev = 1;
        n++;
      end else begin
        have_prev = 0;
      end
      k++;
      step();
    end
    host.wr_valid = 1'b0;
    exp_cur = with_we(e_idle(), op, pa, pd);
    exp_cur.done = 1'b1;
    step();
    $display("load op=%0d addr=%03h len=%0d beats=%0d cycles=%0d", op, addr, len, n, k);
  endtask

  task automatic do_run(input int cyc);
    issue(OP_RUN, 9'h0, 9'h0, 16'(cyc));
    repeat (RST_CYC) begin exp_cur = e_busy(1'b0, 1'b0); step(); end
    repeat (cyc) begin exp_cur = e_busy(1'b1, 1'b1); step(); end
    repeat (DRAIN_CYC) begin exp_cur = e_busy(1'b1, 1'b0); step(); end
    exp_cur = e_idle(); exp_cur.done = 1'b1;
    step();
    $display("run cycles=%0d pc_en_seen=%0d", cyc, pc_cnt);
  endtask

  task automatic do_read(input logic [8:0] addr, input logic [8:0] len, input int stall_beat, input int stall_n);
    logic [7:0] a;
    int s;
    issue(OP_READ_D, addr, len, 16'd0);
    for (int w = 0; w <= int'(len); w++) begin
      a = addr[7:0] + 8'(w);
      exp_cur = e_busy(1'b0, 1'b0); exp_cur.chk_daddr = 1'b1; exp_cur.d_addr = a;
      step();
      repeat (READ_LAT) begin exp_cur = e_busy(1'b0, 1'b0); step(); end
      s = (w == stall_beat) ? stall_n : 0;
      for (int j = 0; j <= s; j++) begin
        exp_cur = e_busy(1'b0, 1'b0); exp_cur.rd_valid = 1'b1; exp_cur.rd_data = ref_mem[a];
        host.rd_ready = (j == s);
        step();
      end
      host.rd_ready = 1'b0;
    end
    exp_cur = e_idle(); exp_cur.done = 1'b1;
    step();
    $display("read addr=%02h len=%0d stalled beat %0d for %0d cycles", addr[7:0], len, stall_beat, stall_n);
  endtask

  initial begin
    reset_n = 1'b0;
    host.cmd_valid = 1'b0; host.cmd_op = 2'b00; host.cmd_addr = '0;
    host.cmd_len = '0; host.cmd_cycles = '0;
    host.wr_valid = 1'b0; host.wr_data = '0; host.rd_ready = 1'b0;
`ifdef DP_RUN_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    exp_cur = e_idle(); exp_cur.chk_zero = 1'b1;
    step(); step();
    reset_n = 1'b1;
    step();
    exp_cur = e_idle();
    step();

    // 1: LOAD_I 0x13,0x93,0x113,0x193 at 0..3, done with the last write
    iwe_cnt = 0; done_cnt = 0;
    do_load(OP_LOAD_I, 9'h000, 9'd3, 1'b0);
    chk("lit_load_i_we_count", 64'(iwe_cnt), 64'd4);
    chk("lit_load_i_done_count", 64'(done_cnt), 64'd1);
    chk("lit_last_i_din", 64'(i_mem_din), 64'h193);

    // i_mem address wraps past 0x1FF
    do_load(OP_LOAD_I, 9'h1FF, 9'd1, 1'b0);
    chk("lit_i_wrap_addr", 64'(i_mem_addra), 64'h0);

    // 2: RUN 8 cycles
    pc_cnt = 0;
    do_run(8);
    chk("lit_run8_pc_en", 64'(pc_cnt), 64'd8);

    // 4: LOAD_D with gaps across the d_mem wrap, then RUN 0 (drain only)
    do_load(OP_LOAD_D, 9'h0FE, 9'd3, 1'b1);
    pc_cnt = 0; done_cnt = 0;
    do_run(0);
    chk("lit_run0_pc_en", 64'(pc_cnt), 64'd0);
    chk("lit_run0_done", 64'(done_cnt), 64'd1);
    chk("lit_dmem_ff", dmem[8'hFF], 64'hDA7A_0000_00FF_0001);
    chk("lit_dmem_01", dmem[8'h01], 64'hDA7A_0000_0101_0003);

    // 3: READ_D FE..01 with beat 1 stalled 5 cycles
    do_read(9'h0FE, 9'd3, 1, 5);

    // 5a: reset mid-RUN
    done_cnt = 0;
    issue(OP_RUN, 9'h0, 9'h0, 16'd20);
    repeat (RST_CYC) begin exp_cur = e_busy(1'b0, 1'b0); step(); end
    repeat (4) begin exp_cur = e_busy(1'b1, 1'b1); step(); end
    exp_cur = e_busy(1'b1, 1'b1); reset_n = 1'b0;
    step();
    exp_cur = e_idle(); exp_cur.chk_zero = 1'b1; reset_n = 1'b1;
    step();
    exp_cur = e_idle();
    step(); step();
    chk("lit_reset_run_done", 64'(done_cnt), 64'd0);
    $display("reset during run: dropped");

    // 5b: reset mid-LOAD_D while a beat is being offered
    issue(OP_LOAD_D, 9'h040, 9'd7, 16'd0);
    exp_cur = e_load(); host.wr_valid = 1'b1; host.wr_data = 64'h1111_2222_3333_4444;
    step();
    exp_cur = with_we(e_load(), OP_LOAD_D, 9'h040, 64'h1111_2222_3333_4444);
    host.wr_data = 64'h5555_6666_7777_8888; reset_n = 1'b0;
    step();
    exp_cur = e_idle(); exp_cur.chk_zero = 1'b1; reset_n = 1'b1; host.wr_valid = 1'b0;
    step();
    exp_cur = e_idle();
    step(); step();
    chk("lit_reset_load_done", 64'(done_cnt), 64'd0);
    chk("lit_dmem_40", dmem[8'h40], 64'h1111_2222_3333_4444);
    $display("reset during load_d: dropped");

`ifdef DP_RUN_CTRL_ABORT_EN
    // 6: abort on RUN cycle 3 of 100
    pc_cnt = 0; done_cnt = 0;
    issue(OP_RUN, 9'h0, 9'h0, 16'd100);
    repeat (RST_CYC) begin exp_cur = e_busy(1'b0, 1'b0); step(); end
    repeat (2) begin exp_cur = e_busy(1'b1, 1'b1); step(); end
    exp_cur = e_busy(1'b1, 1'b1); abort = 1'b1;
    step();
    abort = 1'b0;
    repeat (DRAIN_CYC) begin exp_cur = e_busy(1'b1, 1'b0); step(); end
    exp_cur = e_idle(); exp_cur.done = 1'b1;
    step();
    chk("lit_abort_pc_en", 64'(pc_cnt), 64'd3);
    chk("lit_abort_done", 64'(done_cnt), 64'd1);
    $display("run aborted after %0d cycles", pc_cnt);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
